spi_slave: RTL and testbench

SPI slave front-end bridging a serial host to a parallel register/memory port. It decodes a start bit, a read/write flag and an address from MOSI, then streams one or more data bytes. Written bytes are presented on Wr_Data with a Wr_EN strobe; read bytes are requested with Rd_EN and shifted out on MISO. It sits between the chip pins and the register file.

---
 rtl/spi_slave_pkg.sv | 20 ++
 rtl/spi_slave_if.sv | 27 ++
 rtl/spi_slave_shreg.sv | 45 ++++
 rtl/spi_slave.sv | 154 +++++++++++++++
 tb/tb_spi_slave.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front-end.
package spi_slave_pkg;

    localparam int DEF_WIDTH = 8;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WRITE,
        READ
    } state_e;

endpackage

// File: rtl/spi_slave_if.sv
// Pin-side and register-file-side signals of the SPI slave, grouped with modports.
interface spi_slave_if
    import spi_slave_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             SS;
    logic             MOSI;
    logic             MISO;
    logic             Wr_EN;
    logic             Rd_EN;
    logic [WIDTH-1:0] Rd_Data;
    logic [WIDTH-1:0] Address;
    logic [WIDTH-1:0] Wr_Data;

    modport slave (
        input  SS, MOSI, Rd_Data,
        output MISO, Wr_EN, Rd_EN, Address, Wr_Data
    );

    modport master (
        output SS, MOSI, Rd_Data,
        input  MISO, Wr_EN, Rd_EN, Address, Wr_Data
    );

endinterface

// File: rtl/spi_slave_shreg.sv
// WIDTH-bit shift register with parallel load; shifts toward the MSB, serial data enters at bit 0.
module spi_slave_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             ser_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] shifted;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (gi == 0) begin : g_lsb
            assign shifted[gi] = ser_i;
        end else begin : g_upper
            assign shifted[gi] = sr_q[gi-1];
        end
    end

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = shifted;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: start bit, R/W flag, address, then a burst of data words to/from a register port.
// Define SPI_ADDR_AUTOINC_EN to step Address by one for every burst word after the first.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic        SCLK,
    input  logic        RST,
    spi_slave_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rw_q, rw_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             wr_en_q, wr_en_d;
    logic             rd_en_q, rd_en_d;
`ifdef SPI_ADDR_AUTOINC_EN
    logic             first_q, first_d;
`endif

    logic             sr_load;
    logic             sr_shift;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] rx_word;
    logic             last_bit;

    // One register serves as RX in ADDR/WRITE and as TX in READ.
    spi_slave_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk_i   (SCLK),
        .rst_ni  (RST),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .ser_i   (bus.MOSI & (state_q != READ)),
        .data_i  ((state_q == READ) ? bus.Rd_Data : '0),
        .q_o     (sr_q)
    );

    assign rx_word  = {sr_q[WIDTH-2:0], bus.MOSI};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
`ifdef SPI_ADDR_AUTOINC_EN
        first_d  = first_q;
`endif
        if (bus.SS) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.MOSI) state_d = CMD;
                end
                CMD: begin
                    rw_d    = bus.MOSI;
                    cnt_d   = '0;
                    state_d = ADDR;
                end
                ADDR: begin
                    sr_shift = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    if (last_bit) begin
                        addr_d = rx_word;
                        cnt_d  = '0;
`ifdef SPI_ADDR_AUTOINC_EN
                        first_d = 1'b1;
`endif
                        // Loading zeros keeps MISO low until the first read word arrives.
                        sr_load = 1'b1;
                        if (rw_q) begin
                            state_d = READ;
                            rd_en_d = 1'b1;
                        end else begin
                            state_d = WRITE;
                        end
                    end
                end
                WRITE: begin
                    sr_shift = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    if (last_bit) begin
                        cnt_d   = '0;
                        wdata_d = rx_word;
                        wr_en_d = 1'b1;
`ifdef SPI_ADDR_AUTOINC_EN
                        first_d = 1'b0;
                        if (!first_q) addr_d = addr_q + WIDTH'(1);
`endif
                    end
                end
                READ: begin
                    // The cycle after a request is the one that carries Rd_Data.
                    if (rd_en_q) sr_load = 1'b1;
                    else         sr_shift = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (last_bit) begin
                        cnt_d   = '0;
                        rd_en_d = 1'b1;
`ifdef SPI_ADDR_AUTOINC_EN
                        addr_d = addr_q + WIDTH'(1);
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
`ifdef SPI_ADDR_AUTOINC_EN
            first_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
`ifdef SPI_ADDR_AUTOINC_EN
            first_q <= first_d;
`endif
        end
    end

    assign bus.MISO    = (state_q == READ) ? sr_q[WIDTH-1] : 1'b0;
    assign bus.Wr_EN   = wr_en_q;
    assign bus.Rd_EN   = rd_en_q;
    assign bus.Address = addr_q;
    assign bus.Wr_Data = wdata_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: expected outputs per edge come from the frame's edge numbering (E0 = start bit).
// Honours SPI_ADDR_AUTOINC_EN the same way the design does.
module tb_spi_slave;
    import spi_slave_pkg::*;

    localparam int W = 8;
`ifdef SPI_ADDR_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic SCLK = 1'b0;
    logic RST  = 1'b0;

    spi_slave_if #(.WIDTH(W)) bus ();

    spi_slave #(.WIDTH(W)) dut (
        .SCLK (SCLK),
        .RST  (RST),
        .bus  (bus)
    );

    always #5 SCLK = ~SCLK;

    int checks   = 0;
    int failures = 0;

    // Current frame description and values held from earlier frames.
    logic [W-1:0] fdata[$];
    bit           f_rd;
    logic [W-1:0] f_addr;
    int           f_low;
    logic [W-1:0] m_addr  = '0;
    logic [W-1:0] m_wdata = '0;

    int           wr_pulses;
    logic [W-1:0] wr_log[$];
    logic [W-1:0] cap[8];
    logic [W-1:0] exp_list[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] word_at(input int j);
        return (j >= 0 && j < fdata.size()) ? fdata[j] : '0;
    endfunction

    function automatic int last_edge(input int e);
        return (e < f_low) ? e : f_low - 1;
    endfunction

    // Data words whose final bit edge (E(W+1+W*k)) has happened by edge e.
    function automatic int words_done(input int e);
        int x = last_edge(e);
        return (x >= 2 * W + 1) ? (x - W - 1) / W : 0;
    endfunction

    function automatic logic [W-1:0] exp_addr(input int e);
        int inc;
        int wd = words_done(e);
        if (last_edge(e) < W + 1) return m_addr;
        inc = AUTOINC ? (f_rd ? wd : ((wd > 0) ? wd - 1 : 0)) : 0;
        return f_addr + W'(inc);
    endfunction

    function automatic logic [W-1:0] exp_wdata(input int e);
        int wd = words_done(e);
        if (f_rd || wd == 0) return m_wdata;
        return word_at(wd - 1);
    endfunction

    function automatic logic exp_wr_en(input int e);
        return !f_rd && e >= 2 * W + 1 && e < f_low && ((e - W - 1) % W == 0);
    endfunction

    function automatic logic exp_rd_en(input int e);
        return f_rd && e >= W + 1 && e < f_low && ((e - W - 1) % W == 0);
    endfunction

    function automatic logic exp_miso(input int e);
        logic [W-1:0] w;
        if (!f_rd || e < W + 2 || e >= f_low) return 1'b0;
        w = word_at((e - W - 2) / W);
        return w[W - 1 - ((e - W - 2) % W)];
    endfunction

    function automatic logic stim_mosi(input int e);
        logic [W-1:0] w;
        if (e < 0 || e >= f_low) return 1'b0;
        if (e == 0) return 1'b1;
        if (e == 1) return f_rd;
        if (e <= W + 1) return f_addr[W + 1 - e];
        if (f_rd) return e[0];
        w = word_at((e - W - 2) / W);
        return w[W - 1 - ((e - W - 2) % W)];
    endfunction

    // Rd_Data is only meaningful in the cycle before a load edge; junk elsewhere.
    function automatic logic [W-1:0] stim_rdata(input int e);
        if (f_rd && e >= W + 2 && ((e - W - 2) % W == 0)) return word_at((e - W - 2) / W);
        return 8'hFF;
    endfunction

    task automatic run_frame(input bit rd, input logic [W-1:0] addr, input int low,
                             input int lead, input int total);
        int e;
        int j;
        logic [W-1:0] w;
        logic [W-1:0] next_addr;
        logic [W-1:0] next_wdata;
        f_rd = rd; f_addr = addr; f_low = low;
        wr_pulses = 0;
        wr_log.delete();
        foreach (cap[i]) cap[i] = '0;
        for (int i = 0; i < lead + total; i++) begin
            e = i - lead;
            @(negedge SCLK);
            bus.SS      = (e < low) ? 1'b0 : 1'b1;
            bus.MOSI    = stim_mosi(e);
            bus.Rd_Data = stim_rdata(e);
            @(posedge SCLK);
            #1;
            chk($sformatf("wr_en@E%0d", e),   32'(bus.Wr_EN),   32'(exp_wr_en(e)));
            chk($sformatf("rd_en@E%0d", e),   32'(bus.Rd_EN),   32'(exp_rd_en(e)));
            chk($sformatf("miso@E%0d", e),    32'(bus.MISO),    32'(exp_miso(e)));
            chk($sformatf("address@E%0d", e), 32'(bus.Address), 32'(exp_addr(e)));
            chk($sformatf("wr_data@E%0d", e), 32'(bus.Wr_Data), 32'(exp_wdata(e)));
            if (bus.Wr_EN === 1'b1) begin
                wr_pulses++;
                wr_log.push_back(bus.Wr_Data);
            end
            if (rd && e >= W + 2 && e < low) begin
                j = (e - W - 2) / W;
                w = cap[j];
                w[W - 1 - ((e - W - 2) % W)] = bus.MISO;
                cap[j] = w;
            end
        end
        next_addr  = exp_addr(total - 1);
        next_wdata = exp_wdata(total - 1);
        m_addr  = next_addr;
        m_wdata = next_wdata;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.SS = 1'b1; bus.MOSI = 1'b0; bus.Rd_Data = '0;
        RST = 1'b0;
        repeat (3) @(posedge SCLK);
        #1;
        chk("reset_address", 32'(bus.Address), 32'h0);
        chk("reset_wr_data", 32'(bus.Wr_Data), 32'h0);
        chk("reset_wr_en",   32'(bus.Wr_EN),   32'h0);
        chk("reset_rd_en",   32'(bus.Rd_EN),   32'h0);
        chk("reset_miso",    32'(bus.MISO),    32'h0);
        @(negedge SCLK);
        RST = 1'b1;
        repeat (2) @(negedge SCLK);

        // Single write, preceded by idle zeros with SS low.
        fdata = {8'h1B};
        run_frame(1'b0, 8'h35, 2 * W + 2, 2, 2 * W + 4);
        chk("single_wr_address", 32'(bus.Address), 32'h35);
        chk("single_wr_data",    32'(bus.Wr_Data), 32'h1B);
        chk("single_wr_pulses",  32'(wr_pulses),   32'd1);

        fdata = {8'h1B, 8'hCA, 8'h52, 8'hCA, 8'h1E};
        exp_list = '{8'h1B, 8'hCA, 8'h52, 8'hCA, 8'h1E};
        run_frame(1'b0, 8'h35, W + 2 + 5 * W, 0, W + 4 + 5 * W);
        chk("burst_wr_pulses", 32'(wr_pulses), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("burst_wr_word%0d", i),
                32'((i < wr_log.size()) ? wr_log[i] : 8'hxx), 32'(exp_list[i]));
        chk("burst_wr_address", 32'(bus.Address), AUTOINC ? 32'h39 : 32'h35);

        fdata = {8'h1B};
        run_frame(1'b1, 8'h35, 2 * W + 2, 0, 2 * W + 4);
        chk("single_rd_byte",    32'(cap[0]),      32'h1B);
        chk("single_rd_address", 32'(bus.Address), AUTOINC ? 32'h36 : 32'h35);

        fdata = {8'hDB, 8'hCA, 8'h52, 8'hCA, 8'h1E};
        exp_list = '{8'hDB, 8'hCA, 8'h52, 8'hCA, 8'h1E};
        run_frame(1'b1, 8'h35, W + 2 + 5 * W, 0, W + 4 + 5 * W);
        for (int i = 0; i < 5; i++)
            chk($sformatf("burst_rd_word%0d", i), 32'(cap[i]), 32'(exp_list[i]));
        chk("burst_rd_address", 32'(bus.Address), AUTOINC ? 32'h3A : 32'h35);

        // SS rises after four bits of the first write word.
        fdata = {8'h77};
        run_frame(1'b0, 8'h40, W + 2 + 4, 0, W + 8);
        chk("abort_wr_pulses",  32'(wr_pulses),   32'd0);
        chk("abort_wr_data",    32'(bus.Wr_Data), 32'h1E);
        chk("abort_wr_address", 32'(bus.Address), 32'h40);

        // Reset asserted while the first read bit is on MISO.
        fdata = {8'hDB};
        run_frame(1'b1, 8'h35, 100, 0, W + 3);
        chk("miso_before_rst", 32'(bus.MISO), 32'h1);
        #1 RST = 1'b0;
        #1;
        chk("rst_mid_miso",    32'(bus.MISO),    32'h0);
        chk("rst_mid_rd_en",   32'(bus.Rd_EN),   32'h0);
        chk("rst_mid_address", 32'(bus.Address), 32'h0);
        chk("rst_mid_wr_data", 32'(bus.Wr_Data), 32'h0);
        bus.SS = 1'b1;
        @(negedge SCLK);
        RST = 1'b1;
        m_addr = '0;
        m_wdata = '0;
        repeat (2) @(negedge SCLK);

        // Two-word write at the top address exercises wrap-around.
        fdata = {8'h3C, 8'hC3};
        run_frame(1'b0, 8'hFF, W + 2 + 2 * W, 0, W + 4 + 2 * W);
        chk("wrap_wr_pulses",  32'(wr_pulses),   32'd2);
        chk("wrap_wr_data",    32'(bus.Wr_Data), 32'hC3);
        chk("wrap_wr_address", 32'(bus.Address), AUTOINC ? 32'h00 : 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
